// File: rtl/pipes_pkg.sv
// Shared pipeline types for the front end.
// Fetch FSM states, reset vector and fetch-to-decode bundle.
package pipes;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FULL
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] raw_instr;
    } fetch_data_t;

    function automatic logic [63:0] align_pc(
        input logic [63:0] pc
    );
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding bus request,
// a one-entry instruction buffer and redirect handling.
module fetch_ctrl
    import pipes::*;
#(
    parameter logic [63:0] RESET_PC = pipes::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        fetch_valid,
    output fetch_data_t fetch_data,
    output logic [63:0] fetch_pc,
    input  logic        fetch_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] fetch_count
);

    fetch_state_t state;
    logic [63:0]  pc;
    logic [63:0]  pending_pc;
    logic         discard;
    logic [31:0]  raw_instr;

    logic [63:0]  redir_pc;
    logic         drop;
    logic [63:0]  resume_pc;

    assign redir_pc  = align_pc(redirect_pc);

    // A redirect arriving with the response kills it just like
    // one that arrived earlier; the newest target wins.
    assign drop      = discard | redirect_valid;
    assign resume_pc = redirect_valid ? redir_pc : pending_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pending_pc  <= '0;
            discard     <= 1'b0;
            fetch_count <= '0;
            raw_instr   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect_valid) begin
                        pc <= redir_pc;
                    end
                end
                REQ: begin
                    if (iresp_addr_ok && iresp_data_ok) begin
                        if (drop) begin
                            pc      <= resume_pc;
                            discard <= 1'b0;
                        end else begin
                            raw_instr <= iresp_data;
                            state     <= FULL;
                        end
                    end else begin
                        if (redirect_valid) begin
                            pending_pc <= redir_pc;
                            discard    <= 1'b1;
                        end
                        if (iresp_addr_ok) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (iresp_data_ok) begin
                        if (drop) begin
                            pc      <= resume_pc;
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            raw_instr <= iresp_data;
                            state     <= FULL;
                        end
                    end else if (redirect_valid) begin
                        pending_pc <= redir_pc;
                        discard    <= 1'b1;
                    end
                end
                FULL: begin
                    if (redirect_valid) begin
                        pc    <= redir_pc;
                        state <= REQ;
                    end else if (fetch_ready) begin
                        pc          <= pc + 64'd4;
                        fetch_count <= fetch_count + 64'd1;
                        state       <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ireq_valid           = (state == REQ);
    assign ireq_addr            = pc;
    assign fetch_valid          = (state == FULL) && !redirect_valid;
    assign fetch_data.raw_instr = raw_instr;
    assign fetch_pc             = pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus
// a randomized bus/decode/redirect run against a stream model.
module tb_fetch_ctrl;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok = 1'b0;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        fetch_valid;
    fetch_data_t fetch_data;
    logic [63:0] fetch_pc;
    logic        fetch_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] fetch_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [63:0] RST = 64'h8000_0000;

    fetch_ctrl dut (
        .clk(clk),
        .reset(reset),
        .ireq_valid(ireq_valid),
        .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data(iresp_data),
        .fetch_valid(fetch_valid),
        .fetch_data(fetch_data),
        .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        #1;
        total_cnt++;
        if (ireq_valid !== 1'b0) $display("FAIL reset_ireq_valid got %b want 0", ireq_valid);
        else pass_cnt++;
        total_cnt++;
        if (fetch_valid !== 1'b0) $display("FAIL reset_fetch_valid got %b want 0", fetch_valid);
        else pass_cnt++;
        total_cnt++;
        if (fetch_pc !== RST) $display("FAIL reset_fetch_pc got %h want %h", fetch_pc, RST);
        else pass_cnt++;
        total_cnt++;
        if (ireq_addr !== RST) $display("FAIL reset_ireq_addr got %h want %h", ireq_addr, RST);
        else pass_cnt++;
        total_cnt++;
        if (fetch_count !== 64'd0) $display("FAIL reset_count got %0d want 0", fetch_count);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (ireq_valid !== 1'b0) $display("FAIL idle_ireq_valid got %b want 0", ireq_valid);
        else pass_cnt++;
        total_cnt++;
        if (fetch_pc !== RST) $display("FAIL idle_fetch_pc got %h want %h", fetch_pc, RST);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ireq_valid !== 1'b1 || ireq_addr !== RST)
            $display("FAIL first_req got v=%b a=%h want v=1 a=%h", ireq_valid, ireq_addr, RST);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        do_reset();
        tick();
        fetch_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = RST + 64'(4 * k);
            #1;
            total_cnt++;
            if (ireq_valid !== 1'b1 || ireq_addr !== exp)
                $display("FAIL b2b_req got v=%b a=%h want v=1 a=%h", ireq_valid, ireq_addr, exp);
            else pass_cnt++;
            iresp_addr_ok = 1'b1;
            iresp_data_ok = 1'b1;
            iresp_data    = mem(exp);
            tick();
            iresp_addr_ok = 1'b0;
            iresp_data_ok = 1'b0;
            #1;
            total_cnt++;
            if (fetch_valid !== 1'b1 || fetch_pc !== exp || fetch_data.raw_instr !== mem(exp))
                $display("FAIL b2b_deliver got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                         fetch_valid, fetch_pc, fetch_data.raw_instr, exp, mem(exp));
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if (fetch_count !== 64'd4) $display("FAIL b2b_count got %0d want 4", fetch_count);
        else pass_cnt++;
        fetch_ready = 1'b0;
    endtask

    task automatic test_wait_latency();
        do_reset();
        tick();
        iresp_addr_ok = 1'b1;
        #1;
        total_cnt++;
        if (ireq_valid !== 1'b1 || ireq_addr !== RST)
            $display("FAIL wait_req got v=%b a=%h want v=1 a=%h", ireq_valid, ireq_addr, RST);
        else pass_cnt++;
        tick();
        iresp_addr_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total_cnt++;
            if (ireq_valid !== 1'b0 || fetch_valid !== 1'b0)
                $display("FAIL wait_hold got req=%b fv=%b want 0 0", ireq_valid, fetch_valid);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if (fetch_valid !== 1'b0) $display("FAIL wait_early got fv=%b want 0", fetch_valid);
        else pass_cnt++;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0010_0093;
        tick();
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        #1;
        total_cnt++;
        if (fetch_valid !== 1'b1 || fetch_data.raw_instr !== 32'h0010_0093 || fetch_pc !== RST)
            $display("FAIL wait_data got v=%b d=%h pc=%h want v=1 d=00100093 pc=%h",
                     fetch_valid, fetch_data.raw_instr, fetch_pc, RST);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            iresp_data_ok = (i == 2);
            iresp_data    = 32'hDEAD_BEEF;
            #1;
            total_cnt++;
            if (fetch_valid !== 1'b1 || fetch_pc !== RST || ireq_valid !== 1'b0 ||
                fetch_count !== 64'd0 || fetch_data.raw_instr !== 32'h0010_0093)
                $display("FAIL stall_hold got fv=%b pc=%h req=%b cnt=%0d d=%h want 1 %h 0 0 00100093",
                         fetch_valid, fetch_pc, ireq_valid, fetch_count, fetch_data.raw_instr, RST);
            else pass_cnt++;
            tick();
        end
        iresp_data_ok = 1'b0;
        #1;
        total_cnt++;
        if (fetch_data.raw_instr !== 32'h0010_0093)
            $display("FAIL stall_ignore got d=%h want 00100093", fetch_data.raw_instr);
        else pass_cnt++;
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        #1;
        total_cnt++;
        if (ireq_valid !== 1'b1 || ireq_addr !== RST + 64'd4 || fetch_count !== 64'd1)
            $display("FAIL stall_release got req=%b a=%h cnt=%0d want 1 %h 1",
                     ireq_valid, ireq_addr, fetch_count, RST + 64'd4);
        else pass_cnt++;
    endtask

    task automatic test_redirect_wait();
        iresp_addr_ok = 1'b1;
        tick();
        iresp_addr_ok  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1002;
        tick();
        redirect_valid = 1'b0;
        iresp_data_ok  = 1'b1;
        iresp_data     = 32'hBAD0_BAD0;
        tick();
        iresp_data_ok = 1'b0;
        #1;
        total_cnt++;
        if (fetch_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_1000)
            $display("FAIL redir_wait got fv=%b req=%b a=%h want 0 1 0000000080001000",
                     fetch_valid, ireq_valid, ireq_addr);
        else pass_cnt++;
        iresp_addr_ok = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = mem(64'h8000_1000);
        tick();
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        #1;
        total_cnt++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 64'h8000_1000 ||
            fetch_data.raw_instr !== mem(64'h8000_1000))
            $display("FAIL redir_wait_fetch got v=%b pc=%h d=%h want 1 80001000 %h",
                     fetch_valid, fetch_pc, fetch_data.raw_instr, mem(64'h8000_1000));
        else pass_cnt++;
    endtask

    task automatic test_redirect_handshake();
        fetch_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        #1;
        total_cnt++;
        if (fetch_valid !== 1'b0) $display("FAIL redir_hs_valid got %b want 0", fetch_valid);
        else pass_cnt++;
        tick();
        redirect_valid = 1'b0;
        fetch_ready    = 1'b0;
        #1;
        total_cnt++;
        if (fetch_count !== 64'd1 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2000)
            $display("FAIL redir_hs got cnt=%0d req=%b a=%h want 1 1 80002000",
                     fetch_count, ireq_valid, ireq_addr);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        iresp_addr_ok = 1'b1;
        tick();
        iresp_addr_ok = 1'b0;
        reset = 1'b1;
        tick();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hFFFF_0000;
        tick();
        reset = 1'b0;
        tick();
        iresp_data_ok = 1'b0;
        #1;
        total_cnt++;
        if (ireq_valid !== 1'b1 || ireq_addr !== RST || fetch_valid !== 1'b0 || fetch_count !== 64'd0)
            $display("FAIL rst_mid got req=%b a=%h fv=%b cnt=%0d want 1 %h 0 0",
                     ireq_valid, ireq_addr, fetch_valid, fetch_count, RST);
        else pass_cnt++;
        iresp_addr_ok = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = mem(RST);
        tick();
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        #1;
        total_cnt++;
        if (fetch_valid !== 1'b1 || fetch_pc !== RST || fetch_data.raw_instr !== mem(RST))
            $display("FAIL rst_mid_fetch got v=%b pc=%h d=%h want 1 %h %h",
                     fetch_valid, fetch_pc, fetch_data.raw_instr, RST, mem(RST));
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        total_cnt++;
        if (ireq_valid !== 1'b1 || ireq_addr !== RST)
            $display("FAIL req_redir_stable got v=%b a=%h want 1 %h", ireq_valid, ireq_addr, RST);
        else pass_cnt++;
        tick();
        redirect_valid = 1'b0;
        #1;
        total_cnt++;
        if (ireq_valid !== 1'b1 || ireq_addr !== RST)
            $display("FAIL req_redir_hold got v=%b a=%h want 1 %h", ireq_valid, ireq_addr, RST);
        else pass_cnt++;
        iresp_addr_ok = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h1234_5678;
        tick();
        #1;
        total_cnt++;
        if (ireq_valid !== 1'b1 || ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL req_redir_target got v=%b a=%h want 1 fffffffffffffffc",
                     ireq_valid, ireq_addr);
        else pass_cnt++;
        iresp_data = mem(64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        fetch_ready   = 1'b1;
        #1;
        total_cnt++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL wrap_deliver got v=%b pc=%h want 1 fffffffffffffffc", fetch_valid, fetch_pc);
        else pass_cnt++;
        tick();
        fetch_ready = 1'b0;
        #1;
        total_cnt++;
        if (ireq_addr !== 64'd0) $display("FAIL pc_wrap got %h want 0", ireq_addr);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [63:0] exp_pc;
        logic [63:0] exp_cnt;
        logic [63:0] out_addr;
        logic [63:0] prev_addr;
        bit          outst;
        bit          prev_pend;
        bit          hung;
        int          lat;
        int          deliveries;
        int          idle_cycles;
        do_reset();
        exp_pc = RST;
        exp_cnt = '0;
        outst = 1'b0;
        prev_pend = 1'b0;
        hung = 1'b0;
        lat = 0;
        out_addr = '0;
        prev_addr = '0;
        deliveries = 0;
        idle_cycles = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                exp_pc = RST;
                exp_cnt = '0;
                outst = 1'b0;
                prev_pend = 1'b0;
            end
            iresp_addr_ok  = 1'b0;
            iresp_data_ok  = 1'b0;
            iresp_data     = $urandom;
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = {($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'h0,
                              32'h8000_0000 | ($urandom & 32'h0000_3FFF)};
            fetch_ready    = ($urandom_range(0, 2) != 0);
            if (ireq_valid) begin
                total_cnt++;
                if (outst) $display("FAIL rand_two_outstanding got req=1 want 0 at cycle %0d", c);
                else pass_cnt++;
                if (prev_pend) begin
                    total_cnt++;
                    if (ireq_addr !== prev_addr)
                        $display("FAIL rand_addr_stable got %h want %h", ireq_addr, prev_addr);
                    else pass_cnt++;
                end
            end
            if (outst) begin
                lat--;
                if (lat == 0) begin
                    iresp_data_ok = 1'b1;
                    iresp_data    = mem(out_addr);
                    outst         = 1'b0;
                end
            end else if (ireq_valid && $urandom_range(0, 1) == 1) begin
                iresp_addr_ok = 1'b1;
                lat = $urandom_range(0, 3);
                if (lat == 0) begin
                    iresp_data_ok = 1'b1;
                    iresp_data    = mem(ireq_addr);
                end else begin
                    outst    = 1'b1;
                    out_addr = ireq_addr;
                end
            end else if (!ireq_valid && $urandom_range(0, 3) == 0) begin
                iresp_data_ok = 1'b1;
            end
            prev_pend = ireq_valid && !iresp_addr_ok;
            prev_addr = ireq_addr;
            #1;
            total_cnt++;
            if (fetch_count !== exp_cnt)
                $display("FAIL rand_count got %0d want %0d", fetch_count, exp_cnt);
            else pass_cnt++;
            if (redirect_valid) begin
                total_cnt++;
                if (fetch_valid !== 1'b0) $display("FAIL rand_redir_valid got %b want 0", fetch_valid);
                else pass_cnt++;
            end
            if (fetch_valid && fetch_ready) begin
                total_cnt++;
                if (fetch_pc !== exp_pc || fetch_data.raw_instr !== mem(exp_pc))
                    $display("FAIL rand_deliver got pc=%h d=%h want pc=%h d=%h",
                             fetch_pc, fetch_data.raw_instr, exp_pc, mem(exp_pc));
                else pass_cnt++;
                exp_pc = exp_pc + 64'd4;
                exp_cnt = exp_cnt + 64'd1;
                deliveries++;
                idle_cycles = 0;
            end else begin
                idle_cycles++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
            if (idle_cycles > 300 && !hung) begin
                hung = 1'b1;
                total_cnt++;
                $display("FAIL rand_progress got %0d idle cycles want <= 300", idle_cycles);
            end
            tick();
        end
        total_cnt++;
        if (deliveries < 200) $display("FAIL rand_throughput got %0d want >= 200", deliveries);
        else pass_cnt++;
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_latency();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 ireq_valid  output  1  SHALL signal an outstanding instruction-bus request.
REQ-005 ireq_addr  output  64  SHALL carry the fetch PC of the request.
REQ-006 iresp_addr_ok  input  1  SHALL indicate the bus accepted the address.
REQ-007 iresp_data_ok  input  1  SHALL indicate iresp_data is valid.
REQ-008 iresp_data  input  32  SHALL carry the returned instruction word.
REQ-009 fetch_valid  output  1  SHALL indicate fetch_data/fetch_pc hold a valid instruction for decode.
REQ-010 fetch_data  output  fetch_data_t  SHALL carry raw_instr of the buffered instruction.
REQ-011 fetch_pc  output  64  SHALL carry the PC of the buffered instruction.
REQ-012 fetch_ready  input  1  SHALL indicate decode accepts fetch_data this cycle.
REQ-013 redirect_valid  input  1  SHALL request a PC change (branch/jump/exception).
REQ-014 redirect_pc  input  64  SHALL carry the new PC; bits [1:0] SHALL be forced to 0.
REQ-015 fetch_count  output  64  SHALL count instructions delivered to decode.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, FULL; REQ-017 IDLE SHALL last one cycle after reset, then go to REQ.
REQ-018 In REQ, ireq_valid=1 and ireq_addr=pc; both SHALL stay stable until iresp_addr_ok.
REQ-019 REQ with addr_ok&&data_ok in the same cycle SHALL latch iresp_data and go to FULL (1-cycle fetch).
REQ-020 REQ with addr_ok only SHALL go to WAIT; WAIT with data_ok SHALL latch data and go to FULL.
REQ-021 ireq_valid SHALL be 0 in IDLE, WAIT, FULL; at most one request outstanding.
REQ-022 fetch_valid SHALL equal (state==FULL) && !redirect_valid.
REQ-023 Handshake fetch_valid&&fetch_ready SHALL set pc<=pc+4, increment fetch_count, go to REQ next cycle.
REQ-024 FULL with !fetch_ready SHALL hold fetch_data/fetch_pc unchanged indefinitely.
REQ-025 Redirect in IDLE or FULL SHALL set pc<=redirect_pc, drop any buffered instruction, go to REQ.
REQ-026 Redirect in REQ before addr_ok SHALL store redirect_pc in pending_pc and set discard; address SHALL NOT change.
REQ-027 Redirect in WAIT SHALL store pending_pc and set discard.
REQ-028 On data_ok with discard set, data SHALL be dropped, pc<=pending_pc, discard cleared, next state REQ.
REQ-029 A later redirect while discard is set SHALL overwrite pending_pc (last redirect wins).
REQ-030 Redirect and handshake in the same cycle: redirect SHALL win; no delivery, fetch_count unchanged.
REQ-031 data_ok in IDLE or FULL SHALL be ignored.
REQ-032 pc+4 SHALL wrap modulo 2^64; fetch_count SHALL wrap modulo 2^64.

Reset
REQ-033 reset SHALL set state=IDLE, pc=RESET_PC, discard=0, pending_pc=0, fetch_count=0, raw_instr=0.
REQ-034 During and the cycle after reset, ireq_valid=0, fetch_valid=0, fetch_pc=RESET_PC, ireq_addr=RESET_PC.
REQ-035 Reset mid-transaction SHALL abandon the request; no stale data SHALL ever be delivered.

Structure
REQ-036 fetch_state_t enum (IDLE, REQ, WAIT, FULL) and the RESET_PC constant SHALL live in the pipes package.
REQ-037 fetch_data_t SHALL be reused from the pipes package for fetch_data.
REQ-038 The block SHALL be a single module; no sub-module.

Verification
REQ-039 Reset, bus answers addr_ok+data_ok same cycle, ready=1 -> ireq_addr 0x80000000, 0x80000004, ...; one instr every 2 cycles.
REQ-040 addr_ok at cycle 1, data_ok 3 cycles later with 0x00100093 -> fetch_valid only after data_ok, raw_instr=0x00100093.
REQ-041 FULL, fetch_ready=0 for 5 cycles -> fetch_valid and fetch_pc held, no ireq_valid, fetch_count unchanged.
REQ-042 Redirect to 0x80001002 during WAIT -> returned word dropped, next ireq_addr=0x80001000.
REQ-043 Redirect and fetch_ready in same FULL cycle -> no delivery, fetch_count unchanged, next ireq_addr=redirect_pc.
REQ-044 Assert reset during WAIT, then data_ok -> ignored; first fetch after reset at 0x80000000.
